store_align_unit: RTL and testbench
===================================

# store_align_unit

Store-path counterpart of the load byte-extraction logic: takes a store request (byte address, raw register data, access size) from the execute/memory stage and drives word-aligned write beats with per-byte write masks toward the data memory port. Byte and halfword data are replicated into the correct byte lanes. Misaligned halfword/word stores are split into two word-aligned beats. A valid/ready handshake applies on both sides.

## Interface
- Parameters: none. Address and data widths are fixed at 32.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request
- req_addr  in  32  byte address of store
- req_data  in  32  store data, LSB-justified (rs2)
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- mem_valid  out  1  write beat valid
- mem_ready  in  1  memory accepts beat
- mem_addr  out  32  word-aligned beat address (bits [1:0] = 0)
- mem_wdata  out  32  lane-aligned write data
- mem_wmask  out  4  byte write enables; bit i enables byte lane i
- store_done  out  1  one-cycle pulse: request fully written or rejected
- store_err  out  1  one-cycle pulse with store_done for illegal size

## Operation
- Lane generation from captured request, with off = addr[1:0]:
  - base mask = 4'h1 / 4'h3 / 4'hF for byte / half / word.
  - m8[7:0] = base << off.
  - d64[63:0] = {32'b0, data masked to size} << (8*off).
- Beat 0:
  - mem_addr = {addr[31:2], 2'b00}.
  - mem_wmask = m8[3:0].
  - mem_wdata = d64[31:0].
- Beat 1 is issued only if m8[7:4] != 0:
  - mem_addr = beat0 address + 4, modulo 2^32 (wraps: 0xFFFFFFFC + 4 → 0x00000000).
  - mem_wmask = m8[7:4].
  - mem_wdata = d64[63:32].
- Data lanes not enabled by mem_wmask are driven 0.
- States:
  - IDLE: req_ready = 1. On req_valid, capture addr/data/size.
    - size = 11 → ERR.
    - otherwise → BEAT0.
  - BEAT0: mem_valid = 1. On mem_ready:
    - → BEAT1 if split.
    - else → IDLE, with store_done pulsed on the following cycle.
  - BEAT1: mem_valid = 1. On mem_ready → IDLE, with store_done pulsed on the following cycle.
  - ERR: one cycle. Pulse store_done and store_err, no memory traffic, → IDLE.
- req_ready = 0 in every state except IDLE. There is no request queueing.
- mem_addr, mem_wdata and mem_wmask are registered and held stable while mem_valid = 1 and mem_ready = 0.
- mem_valid is never withdrawn before the handshake.
- Reset at any time:
  - state → IDLE.
  - Any pending beat is abandoned, and beat 1 of a split store is never issued.
  - All outputs are 0 except req_ready = 1 from the first cycle after reset.

## Timing
- Request accepted in cycle T (req_valid & req_ready) → mem_valid first high in cycle T+1.
- Aligned store with mem_ready held high:
  - beat in T+1.
  - store_done in T+2, with state IDLE and req_ready = 1 in that cycle.
  - Next request can be accepted at T+2.
- Split store with mem_ready held high: beats in T+1 and T+2, store_done in T+3.
- Each cycle of mem_ready = 0 adds one cycle of latency; there is no timeout.
- Illegal size accepted at T → store_done = store_err = 1 at T+1, IDLE at T+2.
- store_done and store_err are registered, high for exactly one cycle.

## Structure
- Shared core package holds:
  - size encodings SZ_BYTE / SZ_HALF / SZ_WORD.
  - the state enum (IDLE, BEAT0, BEAT1, ERR).
- The load-side extractor uses the same size encodings from that package.
- Sub-module store_lane_gen: purely combinational. Maps (off, size, data) → (m8, d64), and is reusable for store-to-load forwarding checks.
- Top level contains the FSM, capture registers and output registers only.

## Test plan
- Byte store: addr 0x1003, data 0xDEADBEEF → one beat, addr 0x1000, wmask 4'h8, wdata 0xEF000000, store_done 2 cycles after accept.
- Aligned half: addr 0x2002, data 0x0000CAFE → one beat, addr 0x2000, wmask 4'hC, wdata 0xCAFE0000.
- Misaligned word: addr 0x3001, data 0x11223344 → two beats:
  - addr 0x3000, wmask 4'hE, wdata 0x22334400.
  - addr 0x3004, wmask 4'h1, wdata 0x00000011.
  - store_done in T+3.
- Backpressure plus wrap: addr 0xFFFFFFFF, half, data 0xABCD, mem_ready low for 3 cycles on each beat →
  - beat 0: addr 0xFFFFFFFC, wmask 4'h8, wdata 0xCD000000, outputs stable while stalled.
  - beat 1: addr 0x00000000, wmask 4'h1, wdata 0x000000AB.
- Illegal size 11 → no mem_valid, store_done and store_err both pulse at T+1, req_ready high at T+2.
- Reset asserted while stalled in BEAT0 of a split store → next cycle mem_valid = 0, req_ready = 1, beat 1 never appears, no store_done.

Source files
------------

// File: rtl/store_align_unit_pkg.sv
// Shared core definitions for the load/store byte-lane logic.
// Holds the access size encodings and the store-side FSM state enum.
package store_align_unit_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/store_align_unit_if.sv
// Store request and memory write-beat bundle.
// master = requester/memory side, slave = store_align_unit.
interface store_align_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        store_done;
    logic        store_err;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask,
        input  store_done, store_err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask,
        output store_done, store_err
    );
endinterface

// File: rtl/store_align_unit_lane_gen.sv
// Combinational byte-lane generator: (offset, size, data) -> 8-lane mask and
// 64-bit lane-aligned data spanning two words. Also usable for forwarding checks.
module store_lane_gen
    import store_align_unit_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [7:0]  m8,
    output logic [63:0] d64
);

    logic [3:0]  base;
    logic [31:0] dmask;

    always_comb begin
        base  = 4'h0;
        dmask = 32'h0;
        case (size)
            SZ_BYTE: begin base = 4'h1; dmask = 32'h0000_00FF; end
            SZ_HALF: begin base = 4'h3; dmask = 32'h0000_FFFF; end
            SZ_WORD: begin base = 4'hF; dmask = 32'hFFFF_FFFF; end
            default: begin base = 4'h0; dmask = 32'h0; end
        endcase
        m8  = {4'h0, base} << off;
        d64 = {32'h0, data & dmask} << {off, 3'b000};
    end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment FSM: turns a byte-addressed store into one or two word-aligned
// write beats with byte masks, and reports completion or an illegal size.
module store_align_unit
    import store_align_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    store_align_unit_if.slave bus
);

    state_t      state;
    logic        req_ready_q;
    logic        mem_valid_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wmask_q;
    logic        store_done_q;
    logic        store_err_q;
    logic [3:0]  hi_wmask_p0;
    logic [31:0] hi_wdata_p0;
    logic [7:0]  m8;
    logic [63:0] d64;
    logic        accept;

    store_lane_gen u_lane_gen (
        .off  (bus.req_addr[1:0]),
        .size (bus.req_size),
        .data (bus.req_data),
        .m8   (m8),
        .d64  (d64)
    );

    assign accept = (state == IDLE) && bus.req_valid;

    // Capture stage: second-word half of the lanes, held until beat 1 is issued
    always_ff @(posedge clk) begin
        if (accept) begin
            hi_wmask_p0 <= m8[7:4];
            hi_wdata_p0 <= d64[63:32];
        end
    end

    // Control and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wmask_q  <= 4'h0;
            store_done_q <= 1'b0;
            store_err_q  <= 1'b0;
        end else begin
            store_done_q <= 1'b0;
            store_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        if (bus.req_size == SZ_ILLEGAL) begin
                            state        <= ERR;
                            store_done_q <= 1'b1;
                            store_err_q  <= 1'b1;
                        end else begin
                            state       <= BEAT0;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                            mem_wmask_q <= m8[3:0];
                            mem_wdata_q <= d64[31:0];
                        end
                    end
                end
                BEAT0: begin
                    if (bus.mem_ready) begin
                        if (hi_wmask_p0 != 4'h0) begin
                            state       <= BEAT1;
                            mem_addr_q  <= mem_addr_q + 32'd4;
                            mem_wmask_q <= hi_wmask_p0;
                            mem_wdata_q <= hi_wdata_p0;
                        end else begin
                            state        <= IDLE;
                            mem_valid_q  <= 1'b0;
                            req_ready_q  <= 1'b1;
                            store_done_q <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (bus.mem_ready) begin
                        state        <= IDLE;
                        mem_valid_q  <= 1'b0;
                        req_ready_q  <= 1'b1;
                        store_done_q <= 1'b1;
                    end
                end
                ERR: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wmask  = mem_wmask_q;
    assign bus.store_done = store_done_q;
    assign bus.store_err  = store_err_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit with a byte-level reference model of
// the expected write beats and literal expectations for the named scenarios.
module tb_store_align_unit;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    store_align_unit_if bus ();

    store_align_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int    pass_cnt = 0;
    int    tot_cnt  = 0;
    beat_t exp_q[$];
    beat_t seen[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: place each stored byte at its own address, then group by word.
    task automatic model_push(input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] size, output int nb);
        beat_t b[2];
        int n;
        logic [31:0] a, w;
        logic [1:0]  lane;
        nb = 0;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
        for (int i = 0; i < n; i++) begin
            a    = addr + i;
            w    = {a[31:2], 2'b00};
            lane = a[1:0];
            if (nb == 0 || b[nb-1].addr != w) begin
                b[nb].addr = w;
                b[nb].mask = 4'h0;
                b[nb].data = 32'h0;
                nb++;
            end
            b[nb-1].mask[lane]          = 1'b1;
            b[nb-1].data[8*lane +: 8]   = data[8*i +: 8];
        end
        for (int i = 0; i < nb; i++) exp_q.push_back(b[i]);
    endtask

    // Compare process: every handshaked beat against the model, and stability while stalled
    logic        pv = 1'b0;
    logic [31:0] p_addr, p_data;
    logic [3:0]  p_mask;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (pv && bus.mem_valid) begin
                chk("stall_addr", bus.mem_addr, p_addr);
                chk("stall_mask", bus.mem_wmask, p_mask);
                chk("stall_data", bus.mem_wdata, p_data);
            end
            if (pv) chk("valid_held", bus.mem_valid, 1'b1);
            if (bus.mem_valid && bus.mem_ready) begin
                if (exp_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_beat: got beat at 0x%0h, expected no beat", bus.mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_addr", bus.mem_addr, e.addr);
                    chk("beat_mask", bus.mem_wmask, e.mask);
                    chk("beat_data", bus.mem_wdata, e.data);
                    seen.push_back('{bus.mem_addr, bus.mem_wmask, bus.mem_wdata});
                end
            end
            pv     = bus.mem_valid && !bus.mem_ready;
            p_addr = bus.mem_addr;
            p_mask = bus.mem_wmask;
            p_data = bus.mem_wdata;
        end
    end

    // Issue one store, apply `stall` cycles of backpressure per beat, check completion timing.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] size, input int stall, input int exp_lat);
        int nb, wc, done_cyc;
        logic err_seen;
        seen.delete();
        model_push(addr, data, size, nb);
        chk("model_latency", (size == 2'b11) ? 1 : 1 + nb * (1 + stall), exp_lat);
        chk("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_size  = size;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("req_ready_busy", bus.req_ready, 1'b0);
        wc = 0;
        done_cyc = -1;
        err_seen = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (bus.store_done) begin
                done_cyc = cyc;
                err_seen = bus.store_err;
                break;
            end
            bus.mem_ready = bus.mem_valid && (wc >= stall);
            if (bus.mem_valid && !bus.mem_ready) wc++;
            else wc = 0;
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;
        chk("done_latency", done_cyc, exp_lat);
        chk("done_err", err_seen, size == 2'b11);
        if (size == 2'b11) begin
            chk("err_no_valid", bus.mem_valid, 1'b0);
            @(posedge clk);
            #1;
            chk("err_ready_after", bus.req_ready, 1'b1);
        end else begin
            chk("done_ready", bus.req_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        chk("done_pulse_end", bus.store_done, 1'b0);
        chk("model_drained", exp_q.size(), 0);
    endtask

    task automatic chk_seen(input int idx, input logic [31:0] a, input logic [3:0] m,
                            input logic [31:0] d);
        if (seen.size() <= idx) begin
            tot_cnt++;
            $display("FAIL seen_beat%0d: got %0d beats, expected beat %0d present", idx, seen.size(), idx);
        end else begin
            chk("lit_addr", seen[idx].addr, a);
            chk("lit_mask", seen[idx].mask, m);
            chk("lit_data", seen[idx].data, d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_data  = 32'h0;
        bus.req_size  = 2'b00;
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_valid", bus.mem_valid, 1'b0);
        chk("rst_done", bus.store_done, 1'b0);
        chk("rst_err", bus.store_err, 1'b0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_mask", bus.mem_wmask, 4'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_store(32'h0000_1003, 32'hDEAD_BEEF, 2'b00, 0, 2);
        chk("byte_beats", seen.size(), 1);
        chk_seen(0, 32'h0000_1000, 4'h8, 32'hEF00_0000);

        do_store(32'h0000_2002, 32'h0000_CAFE, 2'b01, 0, 2);
        chk_seen(0, 32'h0000_2000, 4'hC, 32'hCAFE_0000);

        do_store(32'h0000_3001, 32'h1122_3344, 2'b10, 0, 3);
        chk("split_beats", seen.size(), 2);
        chk_seen(0, 32'h0000_3000, 4'hE, 32'h2233_4400);
        chk_seen(1, 32'h0000_3004, 4'h1, 32'h0000_0011);

        do_store(32'hFFFF_FFFF, 32'h0000_ABCD, 2'b01, 3, 9);
        chk_seen(0, 32'hFFFF_FFFC, 4'h8, 32'hCD00_0000);
        chk_seen(1, 32'h0000_0000, 4'h1, 32'h0000_00AB);

        do_store(32'h0000_7000, 32'h5555_AAAA, 2'b11, 0, 1);
        chk("err_beats", seen.size(), 0);

        do_store(32'h0000_4000, 32'h1234_5678, 2'b10, 1, 3);
        chk_seen(0, 32'h0000_4000, 4'hF, 32'h1234_5678);

        do_store(32'h0000_5000, 32'hFFFF_FF5A, 2'b00, 0, 2);
        chk_seen(0, 32'h0000_5000, 4'h1, 32'h0000_005A);

        do_store(32'h0000_6003, 32'h1234_BEEF, 2'b01, 0, 3);
        chk_seen(0, 32'h0000_6000, 4'h8, 32'hEF00_0000);
        chk_seen(1, 32'h0000_6004, 4'h1, 32'h0000_00BE);

        // Reset while stalled in beat 0 of a split store
        begin
            int nb;
            seen.delete();
            model_push(32'h0000_8002, 32'hA1B2_C3D4, 2'b10, nb);
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'h0000_8002;
            bus.req_data  = 32'hA1B2_C3D4;
            bus.req_size  = 2'b10;
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            bus.mem_ready = 1'b0;
            chk("pre_rst_valid", bus.mem_valid, 1'b1);
            chk("pre_rst_mask", bus.mem_wmask, 4'hC);
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            exp_q.delete();
            chk("mid_rst_valid", bus.mem_valid, 1'b0);
            chk("mid_rst_ready", bus.req_ready, 1'b1);
            chk("mid_rst_done", bus.store_done, 1'b0);
            chk("mid_rst_mask", bus.mem_wmask, 4'h0);
            bus.mem_ready = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                chk("post_rst_valid", bus.mem_valid, 1'b0);
                chk("post_rst_done", bus.store_done, 1'b0);
            end
            bus.mem_ready = 1'b0;
            chk("post_rst_beats", seen.size(), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
